// File: rtl/memchk_pkg.sv
// Shared encodings for the memory-access checker: fault types, access sizes, FSM states.
// Also holds the size-vs-address alignment rule.
package memchk_pkg;

  localparam logic [2:0] FT_NONE     = 3'd0;
  localparam logic [2:0] FT_UNMAPPED = 3'd1;
  localparam logic [2:0] FT_PERM     = 3'd2;
  localparam logic [2:0] FT_MISALIGN = 3'd3;
  localparam logic [2:0] FT_CONFLICT = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_FAULTED = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Size code 3 is reserved, so it is always reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lsb[0];
      SZ_WORD: return |lsb;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_checker_if.sv
// Load/store request bus between the core and the access checker, plus the fault status it reports.
// master = core side (drives requests), slave = checker side (returns grants and status).
interface mem_access_checker_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
);
  logic [ADDR_W-1:0] addr;
  logic              memwrite;
  logic              memread;
  logic [1:0]        size;
  logic              fault_clr;
  logic              rd;
  logic              w;
  logic              fault;
  logic [2:0]        fault_type;
  logic [ADDR_W-1:0] fault_addr;
  logic [CNT_W-1:0]  fault_cnt;
  logic              locked;

  modport master (
    output addr, memwrite, memread, size, fault_clr,
    input  rd, w, fault, fault_type, fault_addr, fault_cnt, locked
  );

  modport slave (
    input  addr, memwrite, memread, size, fault_clr,
    output rd, w, fault, fault_type, fault_addr, fault_cnt, locked
  );
endinterface

// File: rtl/memchk_region_match.sv
// Combinational region lookup: inclusive unsigned BASE..LIMIT compare, lowest index wins on overlap.
module memchk_region_match #(
  parameter int                         ADDR_W       = 32,
  parameter int                         NREGIONS     = 2,
  parameter logic [NREGIONS*ADDR_W-1:0] REGION_BASE  = {32'h0000_1000, 32'h0000_0000},
  parameter logic [NREGIONS*ADDR_W-1:0] REGION_LIMIT = {32'h0000_1FFF, 32'h0000_0FFF},
  parameter logic [NREGIONS*2-1:0]      REGION_PERM  = {2'b01, 2'b11}
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [1:0]        perm
);

  // Scan from the top so a lower-indexed match overwrites a higher one.
  always_comb begin
    hit  = 1'b0;
    perm = 2'b00;
    for (int i = NREGIONS - 1; i >= 0; i--) begin
      if ((addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
          (addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W])) begin
        hit  = 1'b1;
        perm = REGION_PERM[i*2 +: 2];
      end
    end
  end

endmodule

// File: rtl/mem_access_checker.sv
// Region/alignment access checker: grants rd/w one cycle after the request, captures first fault, locks after a fault run.
// No backpressure; a request is evaluated every cycle. MEMCHK_ALIGN_CHECK_EN enables the size-based misalignment check.
module mem_access_checker
  import memchk_pkg::*;
#(
  parameter int                         ADDR_W       = 32,
  parameter int                         NREGIONS     = 2,
  parameter logic [NREGIONS*ADDR_W-1:0] REGION_BASE  = {32'h0000_1000, 32'h0000_0000},
  parameter logic [NREGIONS*ADDR_W-1:0] REGION_LIMIT = {32'h0000_1FFF, 32'h0000_0FFF},
  parameter logic [NREGIONS*2-1:0]      REGION_PERM  = {2'b01, 2'b11},
  parameter int                         CNT_W        = 8,
  parameter int                         LOCK_THRESH  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mem_access_checker_if.slave bus
);

  localparam logic [7:0] LOCK_TH = 8'(LOCK_THRESH);

  state_t            state;
  logic [7:0]        consec;
  logic              rd_q, w_q, fault_q, locked_q;
  logic [2:0]        ftype_q;
  logic [ADDR_W-1:0] faddr_q;
  logic [CNT_W-1:0]  fcnt_q;

  logic              hit;
  logic [1:0]        perm;
  logic [2:0]        ft;
  logic              req, blocked, fault_eff;
  logic [7:0]        consec_inc;
  logic [CNT_W-1:0]  fcnt_inc;

  memchk_region_match #(
    .ADDR_W      (ADDR_W),
    .NREGIONS    (NREGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_LIMIT(REGION_LIMIT),
    .REGION_PERM (REGION_PERM)
  ) u_match (
    .addr(bus.addr),
    .hit (hit),
    .perm(perm)
  );

`ifndef MEMCHK_ALIGN_CHECK_EN
  logic [1:0] size_unused;
  assign size_unused = bus.size;
`endif

  always_comb begin
    ft = FT_NONE;
    if (bus.memread && bus.memwrite)
      ft = FT_CONFLICT;
`ifdef MEMCHK_ALIGN_CHECK_EN
    else if (is_misaligned(bus.size, bus.addr[1:0]))
      ft = FT_MISALIGN;
`endif
    else if (!hit)
      ft = FT_UNMAPPED;
    else if ((bus.memread && !perm[0]) || (bus.memwrite && !perm[1]))
      ft = FT_PERM;
  end

  // A same-cycle clear is applied before the request, so evaluate against the cleared view.
  always_comb begin
    req        = bus.memread | bus.memwrite;
    blocked    = (state == ST_LOCKED) && !bus.fault_clr;
    fault_eff  = fault_q && !bus.fault_clr;
    consec_inc = bus.fault_clr ? 8'd1 : ((consec == 8'hFF) ? consec : consec + 8'd1);
    fcnt_inc   = bus.fault_clr ? CNT_W'(1) : ((&fcnt_q) ? fcnt_q : fcnt_q + CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_OK;
      consec   <= 8'd0;
      rd_q     <= 1'b0;
      w_q      <= 1'b0;
      fault_q  <= 1'b0;
      locked_q <= 1'b0;
      ftype_q  <= FT_NONE;
      faddr_q  <= '0;
      fcnt_q   <= '0;
    end else begin
      rd_q <= 1'b0;
      w_q  <= 1'b0;
      if (bus.fault_clr) begin
        state    <= ST_OK;
        consec   <= 8'd0;
        fault_q  <= 1'b0;
        locked_q <= 1'b0;
        ftype_q  <= FT_NONE;
        faddr_q  <= '0;
        fcnt_q   <= '0;
      end
      if (req && !blocked) begin
        if (ft == FT_NONE) begin
          rd_q   <= bus.memread;
          w_q    <= bus.memwrite;
          consec <= 8'd0;
        end else begin
          consec  <= consec_inc;
          fcnt_q  <= fcnt_inc;
          fault_q <= 1'b1;
          if (!fault_eff) begin
            ftype_q <= ft;
            faddr_q <= bus.addr;
          end
          if (consec_inc >= LOCK_TH) begin
            state    <= ST_LOCKED;
            locked_q <= 1'b1;
          end else begin
            state <= ST_FAULTED;
          end
        end
      end
    end
  end

  assign bus.rd         = rd_q;
  assign bus.w          = w_q;
  assign bus.fault      = fault_q;
  assign bus.fault_type = ftype_q;
  assign bus.fault_addr = faddr_q;
  assign bus.fault_cnt  = fcnt_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_mem_access_checker.sv
// Directed bench for mem_access_checker with default region table (0x0-0xFFF RW, 0x1000-0x1FFF RO).
module tb_mem_access_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_access_checker_if #(.ADDR_W(32), .CNT_W(8)) bus ();

  mem_access_checker #(
    .ADDR_W(32), .NREGIONS(2),
    .REGION_BASE ({32'h0000_1000, 32'h0000_0000}),
    .REGION_LIMIT({32'h0000_1FFF, 32'h0000_0FFF}),
    .REGION_PERM ({2'b01, 2'b11}),
    .CNT_W(8), .LOCK_THRESH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Drive one cycle at the falling edge, then return #1 after the rising edge for sampling.
  task automatic cyc(input logic r, input logic wr, input logic [31:0] a,
                     input logic [1:0] s, input logic clr);
    @(negedge clk);
    bus.memread = r; bus.memwrite = wr; bus.addr = a; bus.size = s; bus.fault_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.memread = 0; bus.memwrite = 0; bus.addr = 0; bus.size = 0; bus.fault_clr = 0;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", bus.rd); end
    checks++; if (bus.w !== 1'b0) begin failures++; $display("FAIL reset_w got=%b exp=0", bus.w); end
    checks++; if (bus.fault !== 1'b0 || bus.locked !== 1'b0) begin failures++; $display("FAIL reset_flags fault=%b locked=%b exp=0/0", bus.fault, bus.locked); end
    checks++; if (bus.fault_type !== 3'd0 || bus.fault_addr !== 32'd0 || bus.fault_cnt !== 8'd0) begin failures++; $display("FAIL reset_capture type=%0d addr=%h cnt=%0d exp=0/0/0", bus.fault_type, bus.fault_addr, bus.fault_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pass();
    cyc(1, 0, 32'h0000_0002, 2'd1, 0);
    checks++; if (bus.rd !== 1'b1 || bus.w !== 1'b0) begin failures++; $display("FAIL pass_read rd=%b w=%b exp=1/0", bus.rd, bus.w); end
    checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL pass_read_fault got=%b exp=0", bus.fault); end
    cyc(0, 0, 32'h0, 2'd0, 0);
    checks++; if (bus.rd !== 1'b0) begin failures++; $display("FAIL pass_one_cycle rd=%b exp=0", bus.rd); end
  endtask

  task automatic test_perm();
    cyc(0, 1, 32'h0000_1008, 2'd2, 0);
    checks++; if (bus.w !== 1'b0 || bus.fault !== 1'b1) begin failures++; $display("FAIL perm_grant w=%b fault=%b exp=0/1", bus.w, bus.fault); end
    checks++; if (bus.fault_type !== 3'd2 || bus.fault_addr !== 32'h1008 || bus.fault_cnt !== 8'd1) begin failures++; $display("FAIL perm_capture type=%0d addr=%h cnt=%0d exp=2/1008/1", bus.fault_type, bus.fault_addr, bus.fault_cnt); end
    cyc(1, 0, 32'h0000_3000, 2'd2, 0);
    checks++; if (bus.fault_type !== 3'd2 || bus.fault_addr !== 32'h1008 || bus.fault_cnt !== 8'd2) begin failures++; $display("FAIL perm_first_kept type=%0d addr=%h cnt=%0d exp=2/1008/2", bus.fault_type, bus.fault_addr, bus.fault_cnt); end
    cyc(0, 0, 32'h0, 2'd0, 1);
    checks++; if (bus.fault !== 1'b0 || bus.fault_type !== 3'd0 || bus.fault_cnt !== 8'd0 || bus.fault_addr !== 32'd0) begin failures++; $display("FAIL perm_clear fault=%b type=%0d cnt=%0d addr=%h exp=0/0/0/0", bus.fault, bus.fault_type, bus.fault_cnt, bus.fault_addr); end
  endtask

  task automatic test_misalign();
    cyc(1, 0, 32'h0000_0001, 2'd2, 0);
`ifdef MEMCHK_ALIGN_CHECK_EN
    checks++; if (bus.rd !== 1'b0 || bus.fault_type !== 3'd3) begin failures++; $display("FAIL misalign rd=%b type=%0d exp=0/3", bus.rd, bus.fault_type); end
`else
    checks++; if (bus.rd !== 1'b1 || bus.fault !== 1'b0) begin failures++; $display("FAIL misalign_off rd=%b fault=%b exp=1/0", bus.rd, bus.fault); end
`endif
    cyc(0, 0, 32'h0, 2'd0, 1);
  endtask

  task automatic test_lock();
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h0000_2000, 2'd2, 0);
    checks++; if (bus.locked !== 1'b0 || bus.fault_cnt !== 8'd3) begin failures++; $display("FAIL lock_early locked=%b cnt=%0d exp=0/3", bus.locked, bus.fault_cnt); end
    cyc(1, 0, 32'h0000_2000, 2'd2, 0);
    checks++; if (bus.locked !== 1'b1 || bus.fault_type !== 3'd1 || bus.fault_cnt !== 8'd4 || bus.fault_addr !== 32'h2000) begin failures++; $display("FAIL lock_reached locked=%b type=%0d cnt=%0d addr=%h exp=1/1/4/2000", bus.locked, bus.fault_type, bus.fault_cnt, bus.fault_addr); end
    cyc(1, 0, 32'h0000_0000, 2'd2, 0);
    checks++; if (bus.rd !== 1'b0 || bus.fault_cnt !== 8'd4) begin failures++; $display("FAIL lock_deny rd=%b cnt=%0d exp=0/4", bus.rd, bus.fault_cnt); end
    cyc(0, 1, 32'h0000_1000, 2'd2, 0);
    checks++; if (bus.w !== 1'b0 || bus.fault_cnt !== 8'd4 || bus.fault_addr !== 32'h2000) begin failures++; $display("FAIL lock_frozen w=%b cnt=%0d addr=%h exp=0/4/2000", bus.w, bus.fault_cnt, bus.fault_addr); end
    cyc(0, 0, 32'h0, 2'd0, 1);
    checks++; if (bus.locked !== 1'b0 || bus.fault !== 1'b0) begin failures++; $display("FAIL lock_clear locked=%b fault=%b exp=0/0", bus.locked, bus.fault); end
    // A passing access breaks the run; idle cycles do not.
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h0000_2000, 2'd2, 0);
    cyc(1, 0, 32'h0000_0100, 2'd2, 0);
    checks++; if (bus.rd !== 1'b1) begin failures++; $display("FAIL run_break_rd rd=%b exp=1", bus.rd); end
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h0000_2000, 2'd2, 0);
    checks++; if (bus.locked !== 1'b0 || bus.fault_cnt !== 8'd6) begin failures++; $display("FAIL run_reset locked=%b cnt=%0d exp=0/6", bus.locked, bus.fault_cnt); end
    cyc(0, 0, 32'h0, 2'd0, 0);
    cyc(1, 0, 32'h0000_2000, 2'd2, 0);
    checks++; if (bus.locked !== 1'b1 || bus.fault_cnt !== 8'd7) begin failures++; $display("FAIL run_idle locked=%b cnt=%0d exp=1/7", bus.locked, bus.fault_cnt); end
    cyc(0, 0, 32'h0, 2'd0, 1);
  endtask

  task automatic test_conflict();
    cyc(1, 1, 32'h0000_0000, 2'd2, 0);
    checks++; if (bus.rd !== 1'b0 || bus.w !== 1'b0 || bus.fault_type !== 3'd4) begin failures++; $display("FAIL conflict rd=%b w=%b type=%0d exp=0/0/4", bus.rd, bus.w, bus.fault_type); end
    cyc(0, 1, 32'h0000_1000, 2'd2, 1);
    checks++; if (bus.fault_cnt !== 8'd1 || bus.fault_type !== 3'd2 || bus.fault_addr !== 32'h1000 || bus.fault !== 1'b1) begin failures++; $display("FAIL clr_with_fault cnt=%0d type=%0d addr=%h fault=%b exp=1/2/1000/1", bus.fault_cnt, bus.fault_type, bus.fault_addr, bus.fault); end
    cyc(1, 0, 32'h0000_0004, 2'd2, 1);
    checks++; if (bus.rd !== 1'b1 || bus.fault !== 1'b0 || bus.fault_cnt !== 8'd0) begin failures++; $display("FAIL clr_with_pass rd=%b fault=%b cnt=%0d exp=1/0/0", bus.rd, bus.fault, bus.fault_cnt); end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 32'h0000_0000, 2'd2, 0);
    checks++; if (bus.rd !== 1'b1 || bus.w !== 1'b0) begin failures++; $display("FAIL b2b_0 rd=%b w=%b exp=1/0", bus.rd, bus.w); end
    cyc(0, 1, 32'h0000_0FFF, 2'd0, 0);
    checks++; if (bus.rd !== 1'b0 || bus.w !== 1'b1) begin failures++; $display("FAIL b2b_1 rd=%b w=%b exp=0/1", bus.rd, bus.w); end
    cyc(1, 0, 32'h0000_1FFF, 2'd0, 0);
    checks++; if (bus.rd !== 1'b1 || bus.w !== 1'b0) begin failures++; $display("FAIL b2b_2 rd=%b w=%b exp=1/0", bus.rd, bus.w); end
    checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL b2b_nofault fault=%b exp=0", bus.fault); end
    cyc(1, 0, 32'h0000_2000, 2'd0, 0);
    checks++; if (bus.rd !== 1'b0 || bus.fault_type !== 3'd1) begin failures++; $display("FAIL b2b_edge_unmapped rd=%b type=%0d exp=0/1", bus.rd, bus.fault_type); end
    cyc(0, 0, 32'h0, 2'd0, 1);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      cyc(1, 0, 32'h0000_4000, 2'd2, 0);
      cyc(1, 0, 32'h0000_0000, 2'd2, 0);
    end
    checks++; if (bus.fault_cnt !== 8'd255 || bus.locked !== 1'b0 || bus.fault_type !== 3'd1) begin failures++; $display("FAIL saturate cnt=%0d locked=%b type=%0d exp=255/0/1", bus.fault_cnt, bus.locked, bus.fault_type); end
    checks++; if (bus.rd !== 1'b1) begin failures++; $display("FAIL sat_pass rd=%b exp=1", bus.rd); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.rd !== 1'b0 || bus.fault !== 1'b0 || bus.fault_cnt !== 8'd0 || bus.fault_type !== 3'd0 || bus.locked !== 1'b0) begin failures++; $display("FAIL async_reset rd=%b fault=%b cnt=%0d type=%0d locked=%b exp=0", bus.rd, bus.fault, bus.fault_cnt, bus.fault_type, bus.locked); end
    @(negedge clk);
    bus.memread = 0;
    rst_n = 1'b1;
    cyc(1, 0, 32'h0000_0008, 2'd2, 0);
    checks++; if (bus.rd !== 1'b1) begin failures++; $display("FAIL post_reset_rd rd=%b exp=1", bus.rd); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_perm();
    test_misalign();
    test_lock();
    test_conflict();
    test_back_to_back();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
